// File: rtl/aoi_glitch_filter_if.sv
// aoi_glitch_filter_if
// Groups the filter's data and status signals into one bundle.
//   master : drives din/en/clear_cnt, observes the filtered outputs
//   slave  : the filter itself
// Signals: din (raw AND-OR level), en, clear_cnt, dout, rise, fall,
//          glitch, glitch_cnt[CNT_W-1:0], busy.
interface aoi_glitch_filter_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             en;
  logic             clear_cnt;
  logic             dout;
  logic             rise;
  logic             fall;
  logic             glitch;
  logic [CNT_W-1:0] glitch_cnt;
  logic             busy;

  modport master (
    output din, en, clear_cnt,
    input  dout, rise, fall, glitch, glitch_cnt, busy
  );

  modport slave (
    input  din, en, clear_cnt,
    output dout, rise, fall, glitch, glitch_cnt, busy
  );
endinterface

// File: rtl/aoi_glitch_filter.sv
// aoi_glitch_filter
// Synchronizes the glitch-prone AND-OR output y into the clk domain and
// accepts a new level only after STABLE_CYCLES consecutive equal samples.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of aoi_glitch_filter_if
//          in : din, en, clear_cnt
//          out: dout, rise, fall, glitch, glitch_cnt, busy (all registered)
module aoi_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic               clk,
  input logic               rst,
  aoi_glitch_filter_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, CONF_H, HIGH, CONF_L} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   dout_q, rise_q, fall_q, glitch_q, busy_q;
  logic [CNT_W-1:0]       gcnt_q, gcnt_d;
  logic                   reject;

  assign s = sync_q[SYNC_STAGES-1];

  // --- synchronizer stage: runs regardless of en ---
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
  end

  // A confirm is rejected when s falls back to the level we came from.
  assign reject = bus.en && (((state_q == CONF_H) && !s) ||
                             ((state_q == CONF_L) &&  s));

  // --- filter FSM stage ---
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOW;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          LOW: if (s) begin
            state_q <= CONF_H;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
          end
          CONF_H: begin
            if (!s) begin
              state_q  <= LOW;
              glitch_q <= 1'b1;
              busy_q   <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= HIGH;
              dout_q  <= 1'b1;
              rise_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          HIGH: if (!s) begin
            state_q <= CONF_L;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
          end
          CONF_L: begin
            if (s) begin
              state_q  <= HIGH;
              glitch_q <= 1'b1;
              busy_q   <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= LOW;
              dout_q  <= 1'b0;
              fall_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= LOW;
        endcase
      end
    end
  end

  // Clear has priority over a same-cycle rejection.
  always_comb begin
    gcnt_d = gcnt_q;
    if (bus.clear_cnt) gcnt_d = '0;
    else if (reject)   gcnt_d = sat_inc(gcnt_q);
  end

  // --- glitch counter stage ---
  always_ff @(posedge clk) begin
    if (rst) gcnt_q <= '0;
    else     gcnt_q <= gcnt_d;
  end

  assign bus.dout       = dout_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.glitch     = glitch_q;
  assign bus.glitch_cnt = gcnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aoi_glitch_filter.sv
module tb_aoi_glitch_filter;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  aoi_glitch_filter_if #(.CNT_W(CNT_W)) bus ();

  // The bench feeds din through the same AND-OR function the block sits behind.
  assign bus.din = (a & b) | (c & d);

  aoi_glitch_filter #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_din(input logic v);
    a = v; b = v; c = 1'b0; d = 1'b0;
  endtask

  task automatic do_reset();
    set_din(1'b0);
    bus.en = 1'b1;
    bus.clear_cnt = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.clear_cnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_din(i[0] ? 1'b0 : 1'b1);
      tick(1);
    end
    set_din(1'b0);
    n_cmp++;
    if ({bus.dout, bus.rise, bus.fall, bus.glitch, bus.busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.dout, bus.rise, bus.fall, bus.glitch, bus.busy});
    end
    n_cmp++;
    if (bus.glitch_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_gcnt got=%0d want=0", bus.glitch_cnt);
    end
    rst = 1'b0;
    tick(4);
    n_cmp++;
    if ({bus.dout, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_idle got=%b want=00", {bus.dout, bus.busy});
    end
  endtask

  task automatic test_clean_edges();
    do_reset();
    set_din(1'b1);
    tick(2);
    for (int e = 3; e <= 5; e++) begin
      tick(1);
      n_cmp++;
      if ({bus.busy, bus.dout, bus.rise} !== 3'b100) begin
        n_bad++;
        $display("FAIL rise_confirm_e%0d busy/dout/rise got=%b want=100", e,
                 {bus.busy, bus.dout, bus.rise});
      end
    end
    tick(1);
    n_cmp++;
    if ({bus.busy, bus.dout, bus.rise} !== 3'b011) begin
      n_bad++;
      $display("FAIL rise_e6 busy/dout/rise got=%b want=011",
               {bus.busy, bus.dout, bus.rise});
    end
    tick(1);
    n_cmp++;
    if ({bus.dout, bus.rise} !== 2'b10) begin
      n_bad++;
      $display("FAIL rise_e7 dout/rise got=%b want=10", {bus.dout, bus.rise});
    end
    tick(3);
    set_din(1'b0);
    tick(5);
    n_cmp++;
    if ({bus.dout, bus.fall, bus.busy} !== 3'b101) begin
      n_bad++;
      $display("FAIL fall_e5 dout/fall/busy got=%b want=101",
               {bus.dout, bus.fall, bus.busy});
    end
    tick(1);
    n_cmp++;
    if ({bus.dout, bus.fall, bus.rise} !== 3'b010) begin
      n_bad++;
      $display("FAIL fall_e6 dout/fall/rise got=%b want=010",
               {bus.dout, bus.fall, bus.rise});
    end
    tick(1);
    n_cmp++;
    if (bus.fall !== 1'b0) begin
      n_bad++;
      $display("FAIL fall_e7 fall got=%b want=0", bus.fall);
    end
  endtask

  task automatic test_hazard_dip();
    int n_glitch = 0;
    int n_fall = 0;
    int n_low = 0;
    do_reset();
    a = 1'b1; b = 1'b1; c = 1'b0; d = 1'b0;
    tick(8);
    n_cmp++;
    if (bus.dout !== 1'b1) begin
      n_bad++;
      $display("FAIL hazard_setup dout got=%b want=1", bus.dout);
    end
    // a/b path fast, c/d path two cycles late: y dips low for 2 samples.
    a = 1'b0; b = 1'b0;
    tick(2);
    c = 1'b1; d = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.glitch === 1'b1) n_glitch++;
      if (bus.fall === 1'b1) n_fall++;
      if (bus.dout !== 1'b1) n_low++;
    end
    n_cmp++;
    if (n_glitch !== 1) begin
      n_bad++;
      $display("FAIL hazard_glitch_pulses got=%0d want=1", n_glitch);
    end
    n_cmp++;
    if (n_fall !== 0) begin
      n_bad++;
      $display("FAIL hazard_fall_pulses got=%0d want=0", n_fall);
    end
    n_cmp++;
    if (n_low !== 0) begin
      n_bad++;
      $display("FAIL hazard_dout_low_cycles got=%0d want=0", n_low);
    end
    n_cmp++;
    if (bus.glitch_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL hazard_gcnt got=%0d want=1", bus.glitch_cnt);
    end
  endtask

  task automatic test_saturation_clear();
    logic [CNT_W-1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_din(1'b1);
      tick(1);
      set_din(1'b0);
      tick(3);
      n_cmp++;
      if ({bus.glitch, bus.glitch_cnt} !== {1'b1, want[i]}) begin
        n_bad++;
        $display("FAIL sat_glitch%0d glitch/cnt got=%b/%0d want=1/%0d", i,
                 bus.glitch, bus.glitch_cnt, want[i]);
      end
      tick(2);
    end
    set_din(1'b1);
    tick(1);
    set_din(1'b0);
    tick(2);
    bus.clear_cnt = 1'b1;
    tick(1);
    bus.clear_cnt = 1'b0;
    n_cmp++;
    if ({bus.glitch, bus.glitch_cnt} !== {1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL clear_vs_glitch glitch/cnt got=%b/%0d want=1/0",
               bus.glitch, bus.glitch_cnt);
    end
  endtask

  task automatic test_enable_hold();
    int n_bad_hold = 0;
    do_reset();
    set_din(1'b1);
    tick(4);
    n_cmp++;
    if ({bus.busy, bus.dout} !== 2'b10) begin
      n_bad++;
      $display("FAIL en_setup busy/dout got=%b want=10", {bus.busy, bus.dout});
    end
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if ({bus.dout, bus.rise, bus.fall, bus.glitch} !== 4'b0) n_bad_hold++;
    end
    n_cmp++;
    if (n_bad_hold !== 0) begin
      n_bad++;
      $display("FAIL en_hold bad_cycles got=%0d want=0", n_bad_hold);
    end
    bus.en = 1'b1;
    tick(1);
    n_cmp++;
    if ({bus.dout, bus.rise} !== 2'b00) begin
      n_bad++;
      $display("FAIL en_resume1 dout/rise got=%b want=00", {bus.dout, bus.rise});
    end
    tick(1);
    n_cmp++;
    if ({bus.dout, bus.rise} !== 2'b11) begin
      n_bad++;
      $display("FAIL en_resume2 dout/rise got=%b want=11", {bus.dout, bus.rise});
    end
  endtask

  task automatic test_reset_mid_confirm();
    int n_evt = 0;
    do_reset();
    set_din(1'b1);
    tick(8);
    set_din(1'b0);
    tick(5);
    n_cmp++;
    if ({bus.busy, bus.dout} !== 2'b11) begin
      n_bad++;
      $display("FAIL rstmid_setup busy/dout got=%b want=11", {bus.busy, bus.dout});
    end
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if ({bus.dout, bus.fall, bus.glitch, bus.busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL rstmid_edge dout/fall/glitch/busy got=%b want=0000",
               {bus.dout, bus.fall, bus.glitch, bus.busy});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if ({bus.dout, bus.fall, bus.glitch, bus.rise} !== 4'b0) n_evt++;
    end
    n_cmp++;
    if (n_evt !== 0) begin
      n_bad++;
      $display("FAIL rstmid_after event_cycles got=%0d want=0", n_evt);
    end
  endtask

  initial begin
    bus.en = 1'b1;
    bus.clear_cnt = 1'b0;
    test_reset();
    test_clean_edges();
    test_hazard_dip();
    test_saturation_clear();
    test_enable_hold();
    test_reset_mid_confirm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
